// File: rtl/circuito.sv
// Clocked 5-bit code to 7-segment decoder: 2-flop input sync, registered glyph.
// Ports: clk, rst_n, segments a..g (1 = lit), code bits b1(MSB)..b5(LSB).
module circuito (
  input  logic clk,
  input  logic rst_n,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  input  logic b5,
  input  logic b4,
  input  logic b3,
  input  logic b2,
  input  logic b1
);

  logic [4:0] code_w;
  logic [4:0] sync1_q;
  logic [4:0] sync2_q;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  assign code_w = {b1, b2, b3, b4, b5};

  // Codes 16..31 collapse to a single dash so every code is defined.
  always_comb begin
    seg_d = 7'b0000001;
    if (!sync2_q[4]) begin
      case (sync2_q[3:0])
        4'h0:    seg_d = 7'b1111110;
        4'h1:    seg_d = 7'b0110000;
        4'h2:    seg_d = 7'b1101101;
        4'h3:    seg_d = 7'b1111001;
        4'h4:    seg_d = 7'b0110011;
        4'h5:    seg_d = 7'b1011011;
        4'h6:    seg_d = 7'b1011111;
        4'h7:    seg_d = 7'b1110000;
        4'h8:    seg_d = 7'b1111111;
        4'h9:    seg_d = 7'b1111011;
        4'hA:    seg_d = 7'b1110111;
        4'hB:    seg_d = 7'b0011111;
        4'hC:    seg_d = 7'b1001110;
        4'hD:    seg_d = 7'b0111101;
        4'hE:    seg_d = 7'b1001111;
        default: seg_d = 7'b1000111;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      seg_q   <= '0;
    end else begin
      sync1_q <= code_w;
      sync2_q <= sync1_q;
      seg_q   <= seg_d;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_circuito.sv
// Scoreboard bench for circuito: stimulus queues expected glyphs per cycle,
// a monitor pops and compares them one cycle at a time.
module tb_circuito;

  logic clk;
  logic rst_n;
  logic a, b, c, d, e, f, g;
  logic b5, b4, b3, b2, b1;

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    int         code;
  } exp_t;

  exp_t q[$];
  exp_t ex;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  circuito dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .e    (e),
    .f    (f),
    .g    (g),
    .b5   (b5),
    .b4   (b4),
    .b3   (b3),
    .b2   (b2),
    .b1   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int code);
    logic [6:0] r;
    case (code)
      0:  r = 7'b1111110;
      1:  r = 7'b0110000;
      2:  r = 7'b1101101;
      3:  r = 7'b1111001;
      4:  r = 7'b0110011;
      5:  r = 7'b1011011;
      6:  r = 7'b1011111;
      7:  r = 7'b1110000;
      8:  r = 7'b1111111;
      9:  r = 7'b1111011;
      10: r = 7'b1110111;
      11: r = 7'b0011111;
      12: r = 7'b1001110;
      13: r = 7'b0111101;
      14: r = 7'b1001111;
      15: r = 7'b1000111;
      default: r = 7'b0000001;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] seg_now();
    return {a, b, c, d, e, f, g};
  endfunction

  task automatic check(input string nm, input int code,
                       input logic [6:0] act, input logic [6:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s code=%0d got=%b want=%b t=%0t",
               nm, code, act, req, $time);
    end
  endtask

  task automatic set_code(input int code);
    logic [4:0] v;
    v = code[4:0];
    {b1, b2, b3, b4, b5} = v;
  endtask

  task automatic push(input int at, input int code, input logic [6:0] s);
    exp_t x;
    x.cyc  = at;
    x.seg  = s;
    x.code = code;
    q.push_back(x);
  endtask

  // Drive a code for one cycle; its glyph is due 3 edges later.
  task automatic apply(input int code);
    @(negedge clk);
    set_code(code);
    push(cyc + 3, code, glyph(code));
  endtask

  // Monitor: one output per clock, compared against the queue head.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      ex = q.pop_front();
      if (ex.cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_slot code=%0d due=%0d now=%0d",
                 ex.code, ex.cyc, cyc);
      end else begin
        check("pipe", ex.code, seg_now(), ex.seg);
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout left=%0d want=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_code(21);
    #2;
    check("rst_async", 21, seg_now(), 7'b0000000);
    repeat (2) @(negedge clk);
    check("rst_hold", 21, seg_now(), 7'b0000000);

    // Release with code 0: fill glyph then real glyph 0.
    set_code(0);
    rst_n = 1'b1;
    push(cyc + 1, 0, glyph(0));
    push(cyc + 2, 0, glyph(0));
    push(cyc + 3, 0, glyph(0));

    // Hex sweep, 4 cycles each.
    for (int i = 0; i < 16; i++)
      repeat (4) apply(i);
    // Overflow sweep.
    for (int i = 16; i < 32; i++)
      repeat (2) apply(i);

    // 3 -> 7: 3's glyph persists two more edges.
    repeat (4) apply(3);
    repeat (4) apply(7);
    drain();

    // Mid-cycle reset while 9 is shown.
    repeat (4) apply(9);
    drain();
    check("pre_rst_9", 9, seg_now(), 7'b1111011);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid", 9, seg_now(), 7'b0000000);
    #1 rst_n = 1'b1;
    push(cyc + 1, 0, glyph(0));
    push(cyc + 2, 0, glyph(0));
    push(cyc + 3, 9, glyph(9));
    repeat (3) apply(9);

    // Code changes every cycle.
    for (int i = 0; i < 32; i++)
      apply(i);
    for (int i = 15; i >= 0; i--)
      apply(i);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
